// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver: frame FSM states,
// prefix bytes, the maze game's movement key codes and the parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_D = 8'h23;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Bundle of the raw PS/2 lines and the decoded key event outputs.
// The receiver takes the slave view; whoever drives the PS/2 lines takes master.
interface ps2_scancode_rx_if;
    logic       kClock;
    logic       kData;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_release;
    logic       key_extended;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  kClock,
        input  kData,
        output key_valid,
        output key_code,
        output key_release,
        output key_extended,
        output frame_err,
        output busy
    );

    modport master (
        output kClock,
        output kData,
        input  key_valid,
        input  key_code,
        input  key_release,
        input  key_extended,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length deglitcher: the output only
// adopts a new level after FILTER_LEN consecutive synchronised samples agree.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_out
);

    localparam int CW = 4;

    logic          meta_q;
    logic          sync_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter tracks how many samples in a row disagree with the
    // current filtered level; any agreeing sample restarts the run.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            meta_q <= line_in;
            sync_q <= meta_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line_out = filt_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deglitches kClock/kData, deserialises 11-bit frames,
// folds E0/F0 prefixes into flags and strobes one event per key.
// Optional typematic-repeat suppression is enabled by defining PS2_REPEAT_FILTER_EN.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic           clk,
    input logic           rst,
    ps2_scancode_rx_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Line 0 is kClock, line 1 is kData.
    logic [1:0] raw_lines;
    logic [1:0] filt_lines;

    assign raw_lines = {bus.kData, bus.kClock};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            ps2_line_filter #(
                .FILTER_LEN(FILTER_LEN)
            ) u_filter (
                .clk     (clk),
                .rst     (rst),
                .line_in (raw_lines[gi]),
                .line_out(filt_lines[gi])
            );
        end
    endgenerate

    logic kclk_f;
    logic kdat_f;
    logic kclk_prev_q;
    logic fall;

    assign kclk_f = filt_lines[0];
    assign kdat_f = filt_lines[1];
    assign fall   = kclk_prev_q & ~kclk_f;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    logic          pend_e0_q, pend_e0_d;
    logic          pend_f0_q, pend_f0_d;
    logic          key_valid_q, key_valid_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_release_q, key_release_d;
    logic          key_extended_q, key_extended_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;

`ifdef PS2_REPEAT_FILTER_EN
    logic          held_valid_q, held_valid_d;
    logic [8:0]    held_q, held_d;
`endif

    logic frame_done;
    logic frame_good;
    logic timeout;
    logic forward;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_cnt_d   = to_cnt_q;
        frame_done = 1'b0;
        frame_good = 1'b0;
        timeout    = 1'b0;

        // A sampled edge always wins over an expiring watchdog.
        if (state_q == IDLE || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_d = '0;
            timeout  = 1'b1;
            state_d  = IDLE;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!kdat_f) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {kdat_f, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = kdat_f;
                    state_d = STOP;
                end
                STOP: begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                    frame_good = odd_parity_ok(shift_q, par_q) & kdat_f;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_comb begin
        key_valid_d    = 1'b0;
        frame_err_d    = 1'b0;
        key_code_d     = key_code_q;
        key_release_d  = key_release_q;
        key_extended_d = key_extended_q;
        pend_e0_d      = pend_e0_q;
        pend_f0_d      = pend_f0_q;
        forward        = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
        held_valid_d   = held_valid_q;
        held_d         = held_q;
`endif

        if (timeout || (frame_done && !frame_good)) begin
            frame_err_d = 1'b1;
            pend_e0_d   = 1'b0;
            pend_f0_d   = 1'b0;
        end else if (frame_done) begin
            if (shift_q == PS2_PREFIX_EXT) begin
                pend_e0_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BRK) begin
                pend_f0_d = 1'b1;
            end else begin
                pend_e0_d = 1'b0;
                pend_f0_d = 1'b0;
                forward   = 1'b1;
`ifdef PS2_REPEAT_FILTER_EN
                // Held key tracks the last make so auto-repeat makes are dropped.
                if (!pend_f0_q) begin
                    if (held_valid_q && held_q == {pend_e0_q, shift_q}) begin
                        forward = 1'b0;
                    end else begin
                        held_valid_d = 1'b1;
                        held_d       = {pend_e0_q, shift_q};
                    end
                end else if (held_valid_q && held_q == {pend_e0_q, shift_q}) begin
                    held_valid_d = 1'b0;
                end
`endif
                if (forward) begin
                    key_valid_d    = 1'b1;
                    key_code_d     = shift_q;
                    key_release_d  = pend_f0_q;
                    key_extended_d = pend_e0_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_prev_q    <= 1'b1;
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            par_q          <= 1'b0;
            to_cnt_q       <= '0;
            pend_e0_q      <= 1'b0;
            pend_f0_q      <= 1'b0;
            key_valid_q    <= 1'b0;
            key_code_q     <= 8'h00;
            key_release_q  <= 1'b0;
            key_extended_q <= 1'b0;
            frame_err_q    <= 1'b0;
            busy_q         <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
            held_valid_q   <= 1'b0;
            held_q         <= '0;
`endif
        end else begin
            kclk_prev_q    <= kclk_f;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            par_q          <= par_d;
            to_cnt_q       <= to_cnt_d;
            pend_e0_q      <= pend_e0_d;
            pend_f0_q      <= pend_f0_d;
            key_valid_q    <= key_valid_d;
            key_code_q     <= key_code_d;
            key_release_q  <= key_release_d;
            key_extended_q <= key_extended_d;
            frame_err_q    <= frame_err_d;
            busy_q         <= busy_d;
`ifdef PS2_REPEAT_FILTER_EN
            held_valid_q   <= held_valid_d;
            held_q         <= held_d;
`endif
        end
    end

    assign bus.key_valid    = key_valid_q;
    assign bus.key_code     = key_code_q;
    assign bus.key_release  = key_release_q;
    assign bus.key_extended = key_extended_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.busy         = busy_q;

endmodule
